// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, one-cycle memory latency tracking and a 2-entry {instr, pc} buffer to decode.
// Optional FETCH_CNT_EN macro adds a 32-bit completed-handshake counter output.
module fetch_unit #(
  parameter int                   PC_WIDTH = 10,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [PC_WIDTH-1:0] imem_pc,
  input  logic [31:0]         imem_instr,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [31:0]         id_instr,
  output logic [PC_WIDTH-1:0] id_pc
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0]         fetch_cnt
`endif
);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] infl_pc;
  logic                infl;
  logic [1:0]          cnt;
  logic [31:0]         buf0_instr, buf1_instr;
  logic [PC_WIDTH-1:0] buf0_pc, buf1_pc;
  logic                pop;
  logic [2:0]          occ;
  logic                issue;

  assign imem_pc  = pc_q;
  assign id_valid = (cnt != 2'd0);
  assign id_instr = buf0_instr;
  assign id_pc    = buf0_pc;
  assign pop      = id_valid & id_ready;

  // Occupancy once the in-flight word lands; issuing only below 2 keeps the buffer from overflowing.
  assign occ   = {1'b0, cnt} + {2'b00, infl} - {2'b00, pop};
  assign issue = (occ < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      infl       <= 1'b0;
      infl_pc    <= '0;
      cnt        <= 2'd0;
      buf0_instr <= '0;
      buf0_pc    <= '0;
      buf1_instr <= '0;
      buf1_pc    <= '0;
    end else if (redirect_valid) begin
      cnt  <= 2'd0;
      infl <= 1'b0;
      pc_q <= redirect_pc & ~PC_WIDTH'(3);
    end else begin
      if (issue) begin
        infl    <= 1'b1;
        infl_pc <= pc_q;
        pc_q    <= pc_q + PC_WIDTH'(4);
      end else begin
        infl <= 1'b0;
      end

      // Entry 0 is always the head so decode sees registered data only.
      case ({infl, pop})
        2'b01: begin
          buf0_instr <= buf1_instr;
          buf0_pc    <= buf1_pc;
          cnt        <= cnt - 2'd1;
        end
        2'b10: begin
          if (cnt == 2'd0) begin
            buf0_instr <= imem_instr;
            buf0_pc    <= infl_pc;
          end else begin
            buf1_instr <= imem_instr;
            buf1_pc    <= infl_pc;
          end
          cnt <= cnt + 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            buf0_instr <= imem_instr;
            buf0_pc    <= infl_pc;
          end else begin
            buf0_instr <= buf1_instr;
            buf0_pc    <= buf1_pc;
            buf1_instr <= imem_instr;
            buf1_pc    <= infl_pc;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FETCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
    end else if (pop && !redirect_valid) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed phases push expected {instr, pc} words, a monitor pops them on each handshake.
// Build with FETCH_CNT_EN defined to also exercise the handshake counter.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [9:0]  redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [9:0]  id_pc;
`ifdef FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int hs_base = 0;
  logic [41:0] exp_q[$];
  logic [9:0]  held_pc;
  logic [31:0] held_instr;

  fetch_unit #(.PC_WIDTH(10), .RESET_PC(10'h000)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_pc(imem_pc),
    .imem_instr(imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_instr(id_instr),
    .id_pc(id_pc)
`ifdef FETCH_CNT_EN
    ,
    .fetch_cnt(fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory with one-cycle registered read; word at byte address 4i holds 0x13+i.
  always @(posedge clk) imem_instr <= 32'h13 + 32'(imem_pc[9:2]);

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic rv, input logic [9:0] rpc);
    @(posedge clk);
    #1;
    id_ready       = ready;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic push_run(input logic [9:0] start, input int n);
    logic [9:0] p;
    exp_q.delete();
    p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({32'h13 + 32'(p[9:2]), p});
      p = p + 10'd4;
    end
  endtask

  // Monitor: every accepted handshake must match the next expected word.
  always @(negedge clk) begin
    if (rst_n && id_valid && id_ready && !redirect_valid) begin
      hs_count++;
      if (exp_q.size() == 0) begin
        checkOutput("sb_underflow", 64'd1, 64'd0);
      end else begin
        checkOutput("sb_pc", 64'(id_pc), 64'(exp_q[0][9:0]));
        checkOutput("sb_instr", 64'(id_instr), 64'(exp_q[0][41:10]));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_restart();
    @(negedge clk);
    checkOutput("c0_imem_pc", 64'(imem_pc), 64'h000);
    checkOutput("c0_valid", 64'(id_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 10'h000);
    @(negedge clk);
    checkOutput("c1_valid", 64'(id_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 10'h000);
    @(negedge clk);
    checkOutput("c2_valid", 64'(id_valid), 64'd1);
    checkOutput("c2_pc", 64'(id_pc), 64'h000);
    checkOutput("c2_instr", 64'(id_instr), 64'h13);
  endtask

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 64'(id_valid), 64'd0);
    checkOutput("rst_instr", 64'(id_instr), 64'd0);
    checkOutput("rst_pc", 64'(id_pc), 64'd0);
    checkOutput("rst_imem_pc", 64'(imem_pc), 64'h000);
`ifdef FETCH_CNT_EN
    checkOutput("rst_fetch_cnt", 64'(fetch_cnt), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    id_ready = 1'b1;
    push_run(10'h000, 300);
    check_restart();

    // Stall during cycles 4..9: head 0x008 and imem_pc 0x010 must hold.
    applyStimulus(1'b1, 1'b0, 10'h000);
    applyStimulus(1'b0, 1'b0, 10'h000);
    @(negedge clk);
    held_pc    = id_pc;
    held_instr = id_instr;
    checkOutput("stall_head_pc", 64'(held_pc), 64'h008);
    for (int c = 5; c <= 9; c++) begin
      applyStimulus(1'b0, 1'b0, 10'h000);
      @(negedge clk);
      checkOutput("stall_valid", 64'(id_valid), 64'd1);
      checkOutput("stall_pc", 64'(id_pc), 64'(held_pc));
      checkOutput("stall_instr", 64'(id_instr), 64'(held_instr));
      checkOutput("stall_imem_pc", 64'(imem_pc), 64'h010);
    end
    repeat (6) applyStimulus(1'b1, 1'b0, 10'h000);

    // Fill the buffer, then redirect to 0x107 with a live handshake that must be dropped.
    repeat (3) applyStimulus(1'b0, 1'b0, 10'h000);
    applyStimulus(1'b1, 1'b1, 10'h107);
    push_run(10'h104, 40);
    @(negedge clk);
    checkOutput("redir_full_valid", 64'(id_valid), 64'd1);
    applyStimulus(1'b1, 1'b0, 10'h000);
    @(negedge clk);
    checkOutput("redir_r1_valid", 64'(id_valid), 64'd0);
    checkOutput("redir_r1_imem_pc", 64'(imem_pc), 64'h104);
    applyStimulus(1'b1, 1'b0, 10'h000);
    @(negedge clk);
    checkOutput("redir_r2_valid", 64'(id_valid), 64'd0);
    applyStimulus(1'b1, 1'b0, 10'h000);
    @(negedge clk);
    checkOutput("redir_r3_valid", 64'(id_valid), 64'd1);
    checkOutput("redir_r3_pc", 64'(id_pc), 64'h104);
    checkOutput("redir_r3_instr", 64'(id_instr), 64'h54);
    repeat (4) applyStimulus(1'b1, 1'b0, 10'h000);

    // Redirect near the top of the address space: 0x3F8, 0x3FC, 0x000, 0x004.
    applyStimulus(1'b1, 1'b1, 10'h3F8);
    push_run(10'h3F8, 40);
    repeat (3) applyStimulus(1'b1, 1'b0, 10'h000);
    @(negedge clk);
    checkOutput("wrap_pc", 64'(id_pc), 64'h3F8);
    checkOutput("wrap_instr", 64'(id_instr), 64'h111);
    repeat (6) applyStimulus(1'b1, 1'b0, 10'h000);

    // Back-to-back redirects: the second target wins.
    applyStimulus(1'b1, 1'b1, 10'h200);
    applyStimulus(1'b1, 1'b1, 10'h040);
    push_run(10'h040, 40);
    repeat (3) applyStimulus(1'b1, 1'b0, 10'h000);
    @(negedge clk);
    checkOutput("b2b_pc", 64'(id_pc), 64'h040);
    repeat (4) applyStimulus(1'b1, 1'b0, 10'h000);

    // Asynchronous reset between edges drops valid immediately.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("async_rst_valid", 64'(id_valid), 64'd0);
    checkOutput("async_rst_imem_pc", 64'(imem_pc), 64'h000);
    repeat (2) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    hs_base = hs_count;
    push_run(10'h000, 60);
    check_restart();

    // Ten handshakes in cycles 2..11, then one coinciding with a redirect in cycle 12.
    repeat (9) applyStimulus(1'b1, 1'b0, 10'h000);
    applyStimulus(1'b1, 1'b1, 10'h080);
    push_run(10'h080, 40);
    @(negedge clk);
    checkOutput("hs_before_redir", 64'(hs_count - hs_base), 64'd10);
    checkOutput("hs_redir_valid", 64'(id_valid), 64'd1);
    applyStimulus(1'b1, 1'b0, 10'h000);
    @(negedge clk);
    checkOutput("hs_after_redir", 64'(hs_count - hs_base), 64'd10);
`ifdef FETCH_CNT_EN
    checkOutput("fetch_cnt", 64'(fetch_cnt), 64'd10);
`endif
    repeat (5) applyStimulus(1'b1, 1'b0, 10'h000);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
